// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding, field widths and ROM entry layout for the tick sequencer
package seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, HOLD = 2'd2, DONE = 2'd3} state_e;
  localparam int ADDR_W_DEF = 5;
  localparam int NOTE_W_DEF = 6;
  localparam int DUR_W_DEF = 6;
  localparam int DUR_LSB = 0;
  localparam int END_MARK = 0;
endpackage

// File: rtl/seq_rom.sv
// seq_rom: combinational pattern table, addr -> {note, dur}
module seq_rom import seq_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NOTE_W = NOTE_W_DEF,
  parameter int DUR_W = DUR_W_DEF
) (
  input  logic [ADDR_W-1:0]       addr_i,
  output logic [NOTE_W+DUR_W-1:0] entry_o
);
  always_comb begin
    case (addr_i)
      ADDR_W'(0): entry_o = {NOTE_W'(10), DUR_W'(2)};
      ADDR_W'(1): entry_o = {NOTE_W'(20), DUR_W'(1)};
      ADDR_W'(2): entry_o = {NOTE_W'(30), DUR_W'(3)};
      default:    entry_o = '0;
    endcase
  end
endmodule

// File: rtl/tick_sequencer.sv
// tick_sequencer: steps through the note ROM, holding each note for its duration in ticks
module tick_sequencer import seq_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NOTE_W = NOTE_W_DEF,
  parameter int DUR_W = DUR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tick,
  input  logic              play,
  input  logic              restart,
  output logic [NOTE_W-1:0] note,
  output logic              note_valid,
  output logic [ADDR_W-1:0] step_addr,
  output logic              busy,
  output logic              done
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DUR_W-1:0] ticks_q, ticks_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic nv_q, nv_d;
  logic [NOTE_W+DUR_W-1:0] entry;
  logic [NOTE_W-1:0] rom_note;
  logic [DUR_W-1:0] rom_dur;
  seq_rom #(.ADDR_W(ADDR_W), .NOTE_W(NOTE_W), .DUR_W(DUR_W)) u_rom (
    .addr_i (addr_q),
    .entry_o(entry)
  );
  assign rom_dur = entry[DUR_LSB +: DUR_W];
  assign rom_note = entry[DUR_LSB+DUR_W +: NOTE_W];
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      ticks_q <= '0;
      note_q <= '0;
      nv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      ticks_q <= ticks_d;
      note_q <= note_d;
      nv_q <= nv_d;
    end
  end
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    ticks_d = ticks_q;
    note_d = note_q;
    nv_d = 1'b0;
    case (state_q)
      IDLE: state_d = play ? FETCH : IDLE;
      FETCH: begin
        if (rom_dur == DUR_W'(END_MARK)) state_d = DONE;
        else begin
          note_d = rom_note;
          ticks_d = rom_dur;
          nv_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // the last address ends the pattern instead of wrapping
        if (tick && play) begin
          if (ticks_q > DUR_W'(1)) ticks_d = ticks_q - DUR_W'(1);
          else if (addr_q != {ADDR_W{1'b1}}) begin
            addr_d = addr_q + ADDR_W'(1);
            state_d = FETCH;
          end else state_d = DONE;
        end
      end
      default: state_d = DONE;
    endcase
    if (restart) begin
      state_d = IDLE;
      addr_d = '0;
      ticks_d = '0;
      note_d = '0;
      nv_d = 1'b0;
    end
  end
  assign note = note_q;
  assign note_valid = nv_q;
  assign step_addr = addr_q;
  assign busy = (state_q == FETCH) || (state_q == HOLD);
  assign done = state_q == DONE;
endmodule

// File: tb/tb_tick_sequencer.sv
// tb_tick_sequencer: directed stimulus checked against a pattern-playback model every cycle
module tb_tick_sequencer;
  logic clock = 1'b0, reset, tick, play, restart;
  logic [5:0] note;
  logic note_valid, busy, done;
  logic [4:0] step_addr;
  int ncmp = 0, nerr = 0, nvc = 0, base = 0;
  bit armed = 0;
  int pn[4] = '{10, 20, 30, 0};
  int pd[4] = '{2, 1, 3, 0};
  int ph = 0, ad = 0, left = 0, nt = 0;
  bit nv = 0;
  tick_sequencer dut (
    .clock(clock), .reset(reset), .tick(tick), .play(play), .restart(restart),
    .note(note), .note_valid(note_valid), .step_addr(step_addr), .busy(busy), .done(done)
  );
  always #5 clock = ~clock;
  function automatic int dur_of(int a);
    return a < 4 ? pd[a] : 0;
  endfunction
  function automatic int note_of(int a);
    return a < 4 ? pn[a] : 0;
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // phase: 0 waiting for play, 1 loading entry, 2 sounding note, 3 pattern finished
  always @(posedge clock) begin
    nv = 0;
    if (reset || restart) begin
      ph = 0; ad = 0; left = 0; nt = 0;
    end else if (ph == 0) ph = play ? 1 : 0;
    else if (ph == 1) begin
      if (dur_of(ad) == 0) ph = 3;
      else begin
        nt = note_of(ad); left = dur_of(ad); nv = 1; ph = 2;
      end
    end else if (ph == 2 && tick && play) begin
      if (left > 1) left--;
      else if (ad < 31) begin ad++; ph = 1; end
      else ph = 3;
    end
  end
  always @(negedge clock) begin
    if (note_valid === 1'b1) nvc++;
    if (armed) begin
      chk("cyc_note", note, nt);
      chk("cyc_note_valid", note_valid, nv);
      chk("cyc_step_addr", step_addr, ad);
      chk("cyc_busy", busy, ph == 1 || ph == 2);
      chk("cyc_done", done, ph == 3);
    end
  end
  task automatic pulse(int n);
    repeat (n) begin
      tick = 1; @(negedge clock);
      tick = 0; repeat (3) @(negedge clock);
    end
  endtask
  task automatic do_restart();
    restart = 1; @(negedge clock);
    restart = 0;
  endtask
  initial begin
    reset = 1; tick = 0; play = 0; restart = 0;
    @(negedge clock); armed = 1;
    @(negedge clock); reset = 0;
    repeat (2) @(negedge clock);
    chk("idle_busy", busy, 0); chk("idle_note", note, 0); chk("idle_done", done, 0);
    base = nvc;
    play = 1; @(negedge clock);
    chk("fetch_busy", busy, 1); chk("fetch_nv", note_valid, 0);
    @(negedge clock);
    chk("first_note", note, 10); chk("first_nv", note_valid, 1);
    @(negedge clock);
    chk("nv_one_cycle", note_valid, 0);
    pulse(2);
    chk("second_note", note, 20); chk("second_addr", step_addr, 1);
    pulse(1);
    chk("third_note", note, 30); chk("third_addr", step_addr, 2);
    pulse(3);
    chk("song_done", done, 1); chk("song_busy", busy, 0);
    chk("song_addr", step_addr, 3); chk("song_note", note, 30);
    chk("nv_pulses", nvc - base, 3);
    do_restart();
    chk("rst_addr", step_addr, 0); chk("rst_done", done, 0); chk("rst_note", note, 0);
    repeat (2) @(negedge clock);
    pulse(3); pulse(1);
    play = 0; pulse(5); play = 1; @(negedge clock);
    chk("pause_note", note, 30); chk("pause_addr", step_addr, 2); chk("pause_done", done, 0);
    pulse(1);
    chk("pause_left1", done, 0);
    pulse(1);
    chk("pause_done_end", done, 1);
    do_restart();
    repeat (2) @(negedge clock);
    pulse(2);
    chk("hold1_note", note, 20);
    do_restart();
    chk("rh_addr", step_addr, 0); chk("rh_note", note, 0); chk("rh_busy", busy, 0);
    @(negedge clock);
    chk("rh_fetch", busy, 1); chk("rh_nv_early", note_valid, 0);
    @(negedge clock);
    chk("rh_note10", note, 10); chk("rh_nv", note_valid, 1);
    pulse(2);
    chk("sim_pre_addr", step_addr, 1);
    tick = 1; restart = 1; @(negedge clock);
    tick = 0; restart = 0;
    chk("sim_addr", step_addr, 0); chk("sim_note", note, 0); chk("sim_busy", busy, 0);
    @(negedge clock);
    chk("sim_no_step2", step_addr, 0);
    @(negedge clock);
    chk("sim_note10", note, 10);
    reset = 1; tick = 1; @(negedge clock);
    chk("mr_note", note, 0); chk("mr_addr", step_addr, 0); chk("mr_busy", busy, 0);
    chk("mr_done", done, 0); chk("mr_nv", note_valid, 0);
    tick = 0; @(negedge clock);
    tick = 1; @(negedge clock);
    tick = 0; play = 0; reset = 0; @(negedge clock);
    chk("mr_idle", busy, 0);
    repeat (3) @(negedge clock);
    chk("mr_idle_hold", busy, 0);
    play = 1; repeat (3) @(negedge clock);
    pulse(6);
    chk("dn_done", done, 1);
    play = 0; pulse(2); play = 1; pulse(2);
    chk("dn_sticky", done, 1); chk("dn_addr", step_addr, 3);
    reset = 1; @(negedge clock); reset = 0;
    chk("dn_reset", done, 0);
    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
